shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised universal shift register: the next generation of the team's 8-bit load/shift-right register.
- Adds configurable width, five shift modes, bidirectional serial I/O, and an auto-shift sequencer that performs N shifts on one Start with a Busy/Done handshake.
- Sits in the logic-processor datapath as the A/B operand register. The control FSM can use either single-step shifts or burst shifts.

Parameters:
- WIDTH, 8, data register width in bits (>= 2).
- CNT_W, 4, width of the burst shift count; max burst = 2^CNT_W - 1.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Load  input  1  parallel load of D.
- D  input  WIDTH  parallel load data.
- Shift_En  input  1  single-step shift using live Mode; ignored while Busy.
- Mode  input  3  shift mode select.
- Shift_In_R  input  1  serial bit entering at MSB on right shifts.
- Shift_In_L  input  1  serial bit entering at LSB on left shifts.
- Start  input  1  begin burst of Count shifts.
- Count  input  CNT_W  burst length.
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse on burst completion.
- Shift_Out_R  output  1  Data_Out[0].
- Shift_Out_L  output  1  Data_Out[WIDTH-1].
- Data_Out  output  WIDTH  register contents.

Behaviour:
- Reset (synchronous, active-high, clock Clk) is the highest priority.
  - Data_Out=0, Busy=0, Done=0, remaining=0, FSM=IDLE.
  - Reset asserted mid-burst aborts the burst with no Done.
- Mode encoding:
  - 000 logical right: {Shift_In_R, Data_Out[W-1:1]}.
  - 001 logical left: {Data_Out[W-2:0], Shift_In_L}.
  - 010 rotate right.
  - 011 rotate left.
  - 100 arithmetic right: MSB replicated.
  - 101-111 hold: no data change.
- Priority per edge: Reset > Load > burst step (RUN) > Start (IDLE) > Shift_En (IDLE) > hold.
- Load:
  - Data_Out <= D.
  - If RUN: the burst aborts, Busy<=0, no Done pulse, and a Start in the same cycle is ignored.
- FSM has two states, IDLE and RUN.
- IDLE + Start with Count=N>0:
  - Capture remaining<=N and latch Mode into burst_mode; Busy<=1; go to RUN.
  - No shift occurs on the capture edge.
- IDLE + Start with Count=0: no shift, Busy stays 0, Done<=1 for one cycle.
- RUN, each edge:
  - Apply one shift using burst_mode; remaining<=remaining-1.
  - Serial inputs are sampled live each step.
  - When remaining==1: Busy<=0, Done<=1, go to IDLE.
- Latency:
  - N shifts occur on edges 1..N after the Start capture edge.
  - Busy is high for exactly N cycles.
  - Done is high the cycle after the last shift and coincides with the final Data_Out.
- Start and Shift_En while Busy are ignored; changes to Mode and Count while Busy do not affect the burst.
- Done is high only one cycle. A Start asserted in the Done cycle (FSM is IDLE) is accepted.
- Shift_Out_R and Shift_Out_L are combinational from Data_Out.
- A burst with hold mode consumes N cycles and pulses Done with data unchanged.

Optional Feature:
- Macro SHREG_ZERO_FLAG_EN.
- Defined: adds output port Zero (1 bit), registered, equal to (next Data_Out == 0). It updates on the same edge as Data_Out and resets to 1.
- Undefined: no Zero port and no extra logic. All other behaviour is identical.

Test Plan:
- WIDTH=8: Reset, Load D=0xB4, Mode=000, Shift_In_R=1, Shift_En one cycle -> Data_Out=0xDA, Shift_Out_R=0.
- Load 0x81, Mode=011, Start Count=3 -> Busy high exactly 3 cycles; Data_Out 0x03, 0x06, 0x0C; Done pulses one cycle with Data_Out=0x0C.
- Load 0x90, Mode=100, Start Count=2, Mode changed to 001 after capture -> Data_Out=0xE4 at Done (burst_mode held).
- Start Count=5, Load D=0x3C asserted on 2nd Busy cycle -> Data_Out=0x3C, Busy=0 next cycle, no Done ever.
- Start Count=0 -> no data change, Busy never 1, Done high one cycle; Start Count=4 with Reset on 2nd Busy cycle -> Data_Out=0, Busy=0, Done=0.
- SHREG_ZERO_FLAG_EN defined: Load 0x01, Mode=000, Shift_In_R=0, Shift_En -> Data_Out=0x00, Zero=1 on the same edge; Load 0x10 -> Zero=0.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register for the logic-processor A/B operand path.
// Parallel load, five shift modes (logical/rotate/arithmetic), single-step
// shifts and an auto-shift burst sequencer with a Busy/Done handshake.
// Optional feature: define SHREG_ZERO_FLAG_EN to add a registered Zero output
// that tracks (Data_Out == 0) on the same edge as Data_Out.
module shift_reg_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic [2:0]       Mode,
  input  logic             Shift_In_R,
  input  logic             Shift_In_L,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Shift_Out_R,
  output logic             Shift_Out_L,
`ifdef SHREG_ZERO_FLAG_EN
  output logic             Zero,
`endif
  output logic [WIDTH-1:0] Data_Out
);

  localparam logic [2:0] ModeLsr  = 3'b000;
  localparam logic [2:0] ModeLsl  = 3'b001;
  localparam logic [2:0] ModeRor  = 3'b010;
  localparam logic [2:0] ModeRol  = 3'b011;
  localparam logic [2:0] ModeAsr  = 3'b100;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] data_q,       data_d;
  logic [CNT_W-1:0] remaining_q,  remaining_d;
  logic [2:0]       burst_mode_q, burst_mode_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;

  // One shift step of the given mode; modes 101-111 hold the data.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] data,
    input logic [2:0]       mode,
    input logic             sin_r,
    input logic             sin_l
  );
    logic [WIDTH-1:0] res;
    res = data;
    case (mode)
      ModeLsr: res = {sin_r, data[WIDTH-1:1]};
      ModeLsl: res = {data[WIDTH-2:0], sin_l};
      ModeRor: res = {data[0], data[WIDTH-1:1]};
      ModeRol: res = {data[WIDTH-2:0], data[WIDTH-1]};
      ModeAsr: res = {data[WIDTH-1], data[WIDTH-1:1]};
      default: res = data;
    endcase
    return res;
  endfunction

  // Next-state: Load > burst step > Start > Shift_En > hold.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    remaining_d  = remaining_q;
    burst_mode_d = burst_mode_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (Load) begin
      // Load aborts any running burst silently; a concurrent Start is dropped.
      data_d      = D;
      state_d     = StIdle;
      busy_d      = 1'b0;
      remaining_d = '0;
    end else if (state_q == StRun) begin
      // Burst uses the mode latched at Start; serial inputs are live.
      data_d      = shift_step(data_q, burst_mode_q, Shift_In_R, Shift_In_L);
      remaining_d = remaining_q - 1'b1;
      if (remaining_q == CNT_W'(1)) begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end else if (Start) begin
      if (Count != '0) begin
        // Capture edge only: the first shift happens on the following edge.
        state_d      = StRun;
        remaining_d  = Count;
        burst_mode_d = Mode;
        busy_d       = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else if (Shift_En) begin
      data_d = shift_step(data_q, Mode, Shift_In_R, Shift_In_L);
    end
  end

  // State and registered outputs; synchronous reset aborts without Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      data_q       <= '0;
      remaining_q  <= '0;
      burst_mode_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      remaining_q  <= remaining_d;
      burst_mode_q <= burst_mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef SHREG_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag registered from the next data value so it lines up with Data_Out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= (data_d == '0);
    end
  end

  assign Zero = zero_q;
`endif

  assign Data_Out    = data_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Shift_Out_R = data_q[0];
  assign Shift_Out_L = data_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, CNT_W=4).
module tb_shift_reg_univ;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Shift_En;
  logic [2:0]       Mode;
  logic             Shift_In_R;
  logic             Shift_In_L;
  logic             Start;
  logic [CNT_W-1:0] Count;
  logic             Busy;
  logic             Done;
  logic             Shift_Out_R;
  logic             Shift_Out_L;
  logic [WIDTH-1:0] Data_Out;
`ifdef SHREG_ZERO_FLAG_EN
  logic             Zero;
`endif

  int num_checks = 0;
  int num_errors = 0;

  shift_reg_univ #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load       (Load),
    .D          (D),
    .Shift_En   (Shift_En),
    .Mode       (Mode),
    .Shift_In_R (Shift_In_R),
    .Shift_In_L (Shift_In_L),
    .Start      (Start),
    .Count      (Count),
    .Busy       (Busy),
    .Done       (Done),
    .Shift_Out_R(Shift_Out_R),
    .Shift_Out_L(Shift_Out_L),
`ifdef SHREG_ZERO_FLAG_EN
    .Zero       (Zero),
`endif
    .Data_Out   (Data_Out)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; D = '0; Shift_En = 1'b0; Mode = 3'b000;
    Shift_In_R = 1'b0; Shift_In_L = 1'b0; Start = 1'b0; Count = '0;
    step();
    step();
    check_eq("rst_data", 32'(Data_Out), 32'h00);
    check_eq("rst_busy", 32'(Busy), 32'h0);
    check_eq("rst_done", 32'(Done), 32'h0);
`ifdef SHREG_ZERO_FLAG_EN
    check_eq("rst_zero", 32'(Zero), 32'h1);
`endif
    Reset = 1'b0;

    // Load then single logical-right shift with Shift_In_R=1.
    Load = 1'b1; D = 8'hB4;
    step();
    Load = 1'b0;
    check_eq("load_b4", 32'(Data_Out), 32'hB4);
    Mode = 3'b000; Shift_In_R = 1'b1; Shift_En = 1'b1;
    step();
    Shift_En = 1'b0;
    check_eq("lsr_data", 32'(Data_Out), 32'hDA);
    check_eq("lsr_sout_r", 32'(Shift_Out_R), 32'h0);
    check_eq("lsr_sout_l", 32'(Shift_Out_L), 32'h1);

    // Single logical-left shift: 0xDA -> 0xB5 with Shift_In_L=1.
    Mode = 3'b001; Shift_In_L = 1'b1; Shift_En = 1'b1;
    step();
    Shift_En = 1'b0;
    check_eq("lsl_data", 32'(Data_Out), 32'hB5);

    // Rotate-left burst of 3 from 0x81.
    Load = 1'b1; D = 8'h81;
    step();
    Load = 1'b0;
    Mode = 3'b011; Start = 1'b1; Count = 4'd3;
    step();
    Start = 1'b0;
    check_eq("rol_cap_busy", 32'(Busy), 32'h1);
    check_eq("rol_cap_data", 32'(Data_Out), 32'h81);
    step();
    check_eq("rol_s1_data", 32'(Data_Out), 32'h03);
    check_eq("rol_s1_busy", 32'(Busy), 32'h1);
    step();
    check_eq("rol_s2_data", 32'(Data_Out), 32'h06);
    check_eq("rol_s2_busy", 32'(Busy), 32'h1);
    check_eq("rol_s2_done", 32'(Done), 32'h0);
    step();
    check_eq("rol_s3_data", 32'(Data_Out), 32'h0C);
    check_eq("rol_s3_busy", 32'(Busy), 32'h0);
    check_eq("rol_s3_done", 32'(Done), 32'h1);
    step();
    check_eq("rol_after_done", 32'(Done), 32'h0);
    check_eq("rol_after_data", 32'(Data_Out), 32'h0C);

    // Arithmetic-right burst with Mode changed after capture.
    Load = 1'b1; D = 8'h90;
    step();
    Load = 1'b0;
    Mode = 3'b100; Start = 1'b1; Count = 4'd2;
    step();
    Start = 1'b0; Mode = 3'b001; Count = 4'd9;
    step();
    check_eq("asr_s1_data", 32'(Data_Out), 32'hC8);
    step();
    check_eq("asr_done_data", 32'(Data_Out), 32'hE4);
    check_eq("asr_done", 32'(Done), 32'h1);
    check_eq("asr_busy", 32'(Busy), 32'h0);

    // Load aborts a burst on its 2nd Busy cycle: no Done ever.
    Mode = 3'b000; Shift_In_R = 1'b0; Start = 1'b1; Count = 4'd5;
    step();
    Start = 1'b0;
    check_eq("abort_busy1", 32'(Busy), 32'h1);
    step();
    check_eq("abort_busy2", 32'(Busy), 32'h1);
    Load = 1'b1; D = 8'h3C; Start = 1'b1; Count = 4'd2;
    step();
    Load = 1'b0; Start = 1'b0;
    check_eq("abort_data", 32'(Data_Out), 32'h3C);
    check_eq("abort_busy", 32'(Busy), 32'h0);
    for (int i = 0; i < 7; i++) begin
      check_eq("abort_no_done", 32'(Done), 32'h0);
      check_eq("abort_no_busy", 32'(Busy), 32'h0);
      step();
    end
    check_eq("abort_hold_data", 32'(Data_Out), 32'h3C);

    // Start with Count=0: immediate Done, no Busy, no data change.
    Start = 1'b1; Count = 4'd0;
    step();
    Start = 1'b0;
    check_eq("cnt0_done", 32'(Done), 32'h1);
    check_eq("cnt0_busy", 32'(Busy), 32'h0);
    check_eq("cnt0_data", 32'(Data_Out), 32'h3C);
    step();
    check_eq("cnt0_done_off", 32'(Done), 32'h0);

    // Reset on the 2nd Busy cycle aborts the burst.
    Mode = 3'b000; Start = 1'b1; Count = 4'd4;
    step();
    Start = 1'b0;
    check_eq("rabort_busy1", 32'(Busy), 32'h1);
    step();
    check_eq("rabort_busy2", 32'(Busy), 32'h1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("rabort_data", 32'(Data_Out), 32'h00);
    check_eq("rabort_busy", 32'(Busy), 32'h0);
    check_eq("rabort_done", 32'(Done), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("rabort_no_done", 32'(Done), 32'h0);
    end

    // Hold-mode burst, then a Start accepted in the Done cycle.
    Load = 1'b1; D = 8'h5A;
    step();
    Load = 1'b0;
    Mode = 3'b101; Start = 1'b1; Count = 4'd2;
    step();
    Start = 1'b0;
    step();
    check_eq("hold_s1_busy", 32'(Busy), 32'h1);
    step();
    check_eq("hold_done", 32'(Done), 32'h1);
    check_eq("hold_data", 32'(Data_Out), 32'h5A);
    Mode = 3'b010; Start = 1'b1; Count = 4'd1; Shift_En = 1'b1;
    step();
    Start = 1'b0; Mode = 3'b000; Shift_In_R = 1'b1;
    check_eq("redo_busy", 32'(Busy), 32'h1);
    check_eq("redo_cap_data", 32'(Data_Out), 32'h5A);
    step();
    Shift_En = 1'b0;
    check_eq("ror_data", 32'(Data_Out), 32'h2D);
    check_eq("ror_done", 32'(Done), 32'h1);
    check_eq("ror_busy", 32'(Busy), 32'h0);

`ifdef SHREG_ZERO_FLAG_EN
    Load = 1'b1; D = 8'h01;
    step();
    Load = 1'b0;
    check_eq("zero_load01", 32'(Zero), 32'h0);
    Mode = 3'b000; Shift_In_R = 1'b0; Shift_En = 1'b1;
    step();
    Shift_En = 1'b0;
    check_eq("zero_shift_data", 32'(Data_Out), 32'h00);
    check_eq("zero_shift_flag", 32'(Zero), 32'h1);
    Load = 1'b1; D = 8'h10;
    step();
    Load = 1'b0;
    check_eq("zero_load10", 32'(Zero), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
